// File: rtl/priority_encoder_hs.sv
// Registered N-to-log2(N) priority encoder with pending-request queuing and valid/ready output.
// Define PRIORITY_ENCODER_RR_EN for round-robin arbitration; default is fixed lowest-index priority.
module priority_encoder_hs #(
    parameter int unsigned N = 4,
    parameter int unsigned W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] D,
    input  logic         D_valid,
    output logic [W-1:0] A,
    output logic         A_valid,
    input  logic         A_ready,
    output logic [N-1:0] pend,
    output logic         dup
);

    typedef enum logic {StIdle, StHold} state_e;

    state_e       state_q, state_d;
    logic [W-1:0] a_q, a_d;
    logic [N-1:0] pend_q, pend_d;
    logic         dup_q, dup_d;

    logic [N-1:0] req, merged, sel_oh;
    logic [W-1:0] sel;
    logic         a_valid, fire, load;

    assign a_valid = (state_q == StHold);
    assign req     = D & {N{D_valid}};
    assign merged  = pend_q | req;
    assign fire    = a_valid & A_ready;
    assign load    = ~a_valid | fire;

`ifdef PRIORITY_ENCODER_RR_EN
    logic [W-1:0] ptr_q, ptr_d;
    logic [W-1:0] sel_hi, sel_lo;
    logic         found_hi, found_lo;

    // Search upward from the pointer; fall back to the lowest set bit to model wrap-around.
    always_comb begin
        sel_hi   = '0;
        sel_lo   = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (merged[i] && !found_lo) begin
                found_lo = 1'b1;
                sel_lo   = W'(i);
            end
            if (merged[i] && !found_hi && (W'(i) >= ptr_q)) begin
                found_hi = 1'b1;
                sel_hi   = W'(i);
            end
        end
        sel = found_hi ? sel_hi : sel_lo;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (load && (merged != '0)) begin
            ptr_d = (sel == W'(N - 1)) ? '0 : sel + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        sel = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (merged[i]) begin
                sel = W'(i);
            end
        end
    end
`endif

    always_comb begin
        sel_oh      = '0;
        sel_oh[sel] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        pend_d  = merged;
        dup_d   = |(req & pend_q);
        if (load) begin
            if (merged != '0) begin
                state_d = StHold;
                a_d     = sel;
                // A same-cycle request for the selected bit is consumed here, not left pending.
                pend_d  = merged & ~sel_oh;
            end else begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            pend_q  <= '0;
            dup_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            pend_q  <= pend_d;
            dup_q   <= dup_d;
        end
    end

    assign A       = a_q;
    assign A_valid = a_valid;
    assign pend    = pend_q;
    assign dup     = dup_q;

endmodule

// File: tb/tb_priority_encoder_hs.sv
// Scoreboard bench for priority_encoder_hs: a set-based reference model predicts the index
// stream, pend and dup; a negedge monitor pops expected indices on every accepted handshake.
module tb_priority_encoder_hs;

    localparam int N = 4;
    localparam int W = $clog2(N);

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] d;
    logic         d_valid;
    logic         a_ready;
    logic [W-1:0] a;
    logic         a_valid;
    logic [N-1:0] pend;
    logic         dup;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    // Model state (after last edge) and predicted state (after next edge).
    logic [N-1:0] m_pend, n_pend;
    bit           m_valid, n_valid, m_dup, n_dup;
    int           m_ptr, n_ptr;

    priority_encoder_hs #(.N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .D      (d),
        .D_valid(d_valid),
        .A      (a),
        .A_valid(a_valid),
        .A_ready(a_ready),
        .pend   (pend),
        .dup    (dup)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // First set position searching upward from p with wrap-around.
    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            int idx = (p + k) % N;
            if (((v >> idx) & 1) != 0) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_pend = '0; m_valid = 0; m_dup = 0; m_ptr = 0;
        n_pend = '0; n_valid = 0; n_dup = 0; n_ptr = 0;
        exp_q.delete();
    endtask

    task automatic predict();
        logic [N-1:0] req, merged, one;
        bit           load;
        int           idx;
        one    = 1;
        req    = d_valid ? d : '0;
        merged = m_pend | req;
        load   = !m_valid || a_ready;
        n_dup  = (req & m_pend) != 0;
        n_pend = merged;
        n_valid = m_valid;
        n_ptr  = m_ptr;
        if (load) begin
            if (merged != 0) begin
                idx     = pick(merged, m_ptr);
                n_valid = 1;
                n_pend  = merged & ~(one << idx);
                exp_q.push_back(idx);
`ifdef PRIORITY_ENCODER_RR_EN
                n_ptr = (idx + 1) % N;
`endif
            end else begin
                n_valid = 0;
            end
        end
    endtask

    task automatic cycle(input logic [N-1:0] dd, input logic dv, input logic rdy);
        @(posedge clk);
        #2;
        m_pend = n_pend; m_valid = n_valid; m_dup = n_dup; m_ptr = n_ptr;
        d       = dd;
        d_valid = dv;
        a_ready = rdy;
        predict();
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("a_valid", int'(a_valid), int'(m_valid));
            check("pend", int'(pend), int'(m_pend));
            check("dup", int'(dup), int'(m_dup));
            if (a_valid && a_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_index", int'(a), -1);
                end else begin
                    check("index", int'(a), exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst = 1'b1; d = '0; d_valid = 1'b0; a_ready = 1'b0;
        model_reset();
        #1;
        check("rst_a", int'(a), 0);
        check("rst_a_valid", int'(a_valid), 0);
        check("rst_pend", int'(pend), 0);
        check("rst_dup", int'(dup), 0);
        @(posedge clk);
        #2 rst = 1'b0;

        // Async reset in the middle of HOLD with A=2.
        cycle(4'b0100, 1'b1, 1'b0);
        cycle(4'b0000, 1'b0, 1'b0);
        check("hold_a", int'(a), 2);
        check("hold_a_valid", int'(a_valid), 1);
        #1 rst = 1'b1;
        #1;
        check("midrst_a", int'(a), 0);
        check("midrst_a_valid", int'(a_valid), 0);
        check("midrst_pend", int'(pend), 0);
        model_reset();
        d_valid = 1'b0; a_ready = 1'b0; d = '0;
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (3) cycle(4'b0000, 1'b0, 1'b1);

        // Single, multi-hot drain, backpressure, duplicate merge, reissue of held index.
        cycle(4'b0100, 1'b1, 1'b1);
        repeat (2) cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b1011, 1'b1, 1'b1);
        repeat (4) cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b0011, 1'b1, 1'b0);
        repeat (5) cycle(4'b0000, 1'b0, 1'b0);
        repeat (3) cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b0101, 1'b1, 1'b0);
        cycle(4'b0000, 1'b0, 1'b0);
        cycle(4'b0100, 1'b1, 1'b0);
        cycle(4'b0001, 1'b1, 1'b0);
        cycle(4'b1111, 1'b0, 1'b0);
        repeat (5) cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b1111, 1'b1, 1'b1);
        repeat (5) cycle(4'b0000, 1'b0, 1'b1);

        // Random traffic with bursty backpressure.
        for (int i = 0; i < 3000; i++) begin
            logic rdy;
            rdy = ((i / 16) % 3 == 0) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
            cycle(N'($urandom), 1'($urandom % 2), rdy);
        end

        repeat (N + 3) cycle(4'b0000, 1'b0, 1'b1);
        check("drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
